// File: rtl/imm_decode_queue.sv
// Opcode-driven immediate decoder feeding a DEPTH-entry FIFO with tag passthrough.
// Optional feature macro: IMM_ZICSR_EN (CSR address / zimm decode for SYSTEM opcodes).
module imm_decode_queue #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;
`ifdef IMM_ZICSR_EN
  localparam logic [2:0] T_Z     = 3'd7;
`endif

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       ty;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  // Callers pre-extend each field to 32 bits; this widens to XLEN.
  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_ill;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];

  always_comb begin
    dec_imm  = '0;
    dec_type = T_NONE;
    dec_ill  = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (op)
        7'b0000011, 7'b1100111: begin
          dec_type = T_I;
          dec_imm  = sx32({{20{in_instr[31]}}, in_instr[31:20]});
        end
        7'b0010011: begin
          if (f3 == 3'b001 || f3 == 3'b101) begin
            dec_type = T_SHAMT;
            dec_imm  = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
          end else begin
            dec_type = T_I;
            dec_imm  = sx32({{20{in_instr[31]}}, in_instr[31:20]});
          end
        end
        7'b0011011: begin
          // Word-sized ops only exist on RV64.
          if (XLEN != 64) begin
            dec_ill = 1'b1;
          end else if (f3 == 3'b001 || f3 == 3'b101) begin
            dec_type = T_SHAMT;
            dec_imm  = XLEN'(in_instr[24:20]);
          end else begin
            dec_type = T_I;
            dec_imm  = sx32({{20{in_instr[31]}}, in_instr[31:20]});
          end
        end
        7'b0100011: begin
          dec_type = T_S;
          dec_imm  = sx32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
        end
        7'b1100011: begin
          dec_type = T_B;
          dec_imm  = sx32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0});
        end
        7'b0110111, 7'b0010111: begin
          dec_type = T_U;
          dec_imm  = sx32({in_instr[31:12], 12'b0});
        end
        7'b1101111: begin
          dec_type = T_J;
          dec_imm  = sx32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0});
        end
        7'b0110011, 7'b0111011, 7'b0001111: begin
          dec_type = T_NONE;
        end
        7'b1110011: begin
`ifdef IMM_ZICSR_EN
          if (f3[2]) begin
            dec_type = T_Z;
            dec_imm  = XLEN'(in_instr[19:15]);
          end else if (f3 != 3'b000) begin
            dec_type = T_I;
            dec_imm  = XLEN'(in_instr[31:20]);
          end
`else
          dec_type = T_NONE;
`endif
        end
        default: dec_ill = 1'b1;
      endcase
    end
  end

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  entry_t             head;

  assign in_ready  = (count_q != CNT_W'(DEPTH)) && !rst;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{imm: dec_imm, ty: dec_type, tag: in_tag, ill: dec_ill};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Stale storage must never leak out while the queue is empty.
  assign out_imm     = out_valid ? head.imm : '0;
  assign out_type    = out_valid ? head.ty  : 3'd0;
  assign out_tag     = out_valid ? head.tag : '0;
  assign out_illegal = out_valid ? head.ill : 1'b0;

endmodule

// File: tb/tb_imm_decode_queue.sv
// Randomized bench for imm_decode_queue: XLEN=32 and XLEN=64 instances driven in lockstep
// and compared against a queue-based reference model each cycle.
module tb_imm_decode_queue;

  localparam int TAG_W = 5;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_ready = 1'b0;

  logic             in_ready32, out_valid32, out_illegal32;
  logic [31:0]      out_imm32;
  logic [2:0]       out_type32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64, out_illegal64;
  logic [63:0]      out_imm64;
  logic [2:0]       out_type64;
  logic [TAG_W-1:0] out_tag64;

  imm_decode_queue #(.XLEN(32), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_type(out_type32), .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  imm_decode_queue #(.XLEN(64), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_type(out_type64), .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [31:0]      mq_instr [$];
  logic [TAG_W-1:0] mq_tag [$];

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Interpret the top bit of a bits-wide field as negative weight.
  function automatic longint sext(input longint v, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half * 2) : v;
  endfunction

  function automatic void ref_decode(input logic [31:0] i, input int xlen,
                                     output logic [63:0] imm, output logic [2:0] ty,
                                     output logic ill);
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    longint v = 0;
    ty = 3'd0; ill = 1'b0;
    if (i[1:0] != 2'b11) ill = 1'b1;
    else if (op == 7'h03 || op == 7'h67 ||
             ((op == 7'h13 || (op == 7'h1B && xlen == 64)) && f3 != 3'b001 && f3 != 3'b101)) begin
      ty = 3'd1; v = sext(longint'(i[31:20]), 12);
    end else if (op == 7'h13) begin
      ty = 3'd6; v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
    end else if (op == 7'h1B && xlen == 64) begin
      ty = 3'd6; v = longint'(i[24:20]);
    end else if (op == 7'h23) begin
      ty = 3'd2; v = sext(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
    end else if (op == 7'h63) begin
      ty = 3'd3;
      v = sext(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
               longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
    end else if (op == 7'h37 || op == 7'h17) begin
      ty = 3'd4; v = sext(longint'(i[31:12]) * 4096, 32);
    end else if (op == 7'h6F) begin
      ty = 3'd5;
      v = sext(longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096 +
               longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
    end else if (op == 7'h33 || op == 7'h3B || op == 7'h0F) begin
      ty = 3'd0;
    end else if (op == 7'h73) begin
`ifdef IMM_ZICSR_EN
      if (f3[2]) begin ty = 3'd7; v = longint'(i[19:15]); end
      else if (f3 != 3'b000) begin ty = 3'd1; v = longint'(i[31:20]); end
`endif
    end else begin
      ill = 1'b1;
    end
    imm = 64'(v);
    if (xlen == 32) imm[63:32] = '0;
  endfunction

  task automatic check_outputs();
    logic [63:0] e_imm32, e_imm64;
    logic [2:0]  e_ty32, e_ty64;
    logic        e_ill32, e_ill64, ne;
    logic [TAG_W-1:0] e_tag;
    ne = (mq_instr.size() > 0);
    e_imm32 = '0; e_imm64 = '0; e_ty32 = '0; e_ty64 = '0; e_ill32 = 0; e_ill64 = 0; e_tag = '0;
    if (ne) begin
      ref_decode(mq_instr[0], 32, e_imm32, e_ty32, e_ill32);
      ref_decode(mq_instr[0], 64, e_imm64, e_ty64, e_ill64);
      e_tag = mq_tag[0];
    end
    check_eq("in_ready32", 64'(in_ready32), 64'(!rst && mq_instr.size() < DEPTH));
    check_eq("in_ready64", 64'(in_ready64), 64'(!rst && mq_instr.size() < DEPTH));
    check_eq("out_valid32", 64'(out_valid32), 64'(ne));
    check_eq("out_valid64", 64'(out_valid64), 64'(ne));
    check_eq("out_imm32", 64'(out_imm32), e_imm32);
    check_eq("out_imm64", out_imm64, e_imm64);
    check_eq("out_type32", 64'(out_type32), 64'(e_ty32));
    check_eq("out_type64", 64'(out_type64), 64'(e_ty64));
    check_eq("out_tag32", 64'(out_tag32), 64'(e_tag));
    check_eq("out_tag64", 64'(out_tag64), 64'(e_tag));
    check_eq("out_illegal32", 64'(out_illegal32), 64'(e_ill32));
    check_eq("out_illegal64", 64'(out_illegal64), 64'(e_ill64));
  endtask

  // Apply one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input logic v, input logic [31:0] instr, input logic [TAG_W-1:0] tag,
                      input logic rdy, input logic fl);
    int sz;
    in_valid = v; in_instr = instr; in_tag = tag; out_ready = rdy; flush = fl;
    sz = mq_instr.size();
    if (fl) begin
      mq_instr.delete(); mq_tag.delete();
    end else begin
      if (sz > 0 && rdy) begin
        void'(mq_instr.pop_front()); void'(mq_tag.pop_front());
      end
      if (v && sz < DEPTH) begin
        mq_instr.push_back(instr); mq_tag.push_back(tag);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r = $urandom();
    logic [6:0]  op;
    case ($urandom_range(0, 15))
      0: op = 7'h03;  1: op = 7'h67;  2: op = 7'h13;  3: op = 7'h1B;
      4: op = 7'h23;  5: op = 7'h63;  6: op = 7'h37;  7: op = 7'h17;
      8: op = 7'h6F;  9: op = 7'h33; 10: op = 7'h3B; 11: op = 7'h0F;
      12: op = 7'h73; 13: op = 7'h13;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    @(negedge clk);
    check_outputs();

    // Single-entry streaming: each step's head is the previous push.
    step(1, 32'hFFF00093, 5'd7, 1, 0);
    check_eq("addi_imm", 64'(out_imm32), 64'hFFFFFFFF);
    check_eq("addi_type", 64'(out_type32), 64'd1);
    check_eq("addi_tag", 64'(out_tag32), 64'd7);
    step(1, 32'hFE112E23, 5'd8, 1, 0);
    check_eq("sw_imm", 64'(out_imm32), 64'hFFFFFFFC);
    check_eq("sw_type", 64'(out_type32), 64'd2);
    step(1, 32'hFFDFF06F, 5'd9, 1, 0);
    check_eq("jal_imm", 64'(out_imm32), 64'hFFFFFFFC);
    check_eq("jal_type", 64'(out_type32), 64'd5);
    step(1, 32'h800002B7, 5'd10, 1, 0);
    check_eq("lui_imm64", out_imm64, 64'hFFFFFFFF80000000);
    check_eq("lui_type64", 64'(out_type64), 64'd4);
    step(1, 32'h0000001B, 5'd11, 1, 0);
    check_eq("addiw_type64", 64'(out_type64), 64'd1);
    check_eq("addiw_ill32", 64'(out_illegal32), 64'd1);
    step(1, 32'h02009093, 5'd12, 1, 0);
    check_eq("slli_imm64", out_imm64, 64'd32);
    step(1, 32'h3002D073, 5'd13, 1, 0);
`ifdef IMM_ZICSR_EN
    check_eq("csrrwi_type", 64'(out_type32), 64'd7);
    check_eq("csrrwi_imm", 64'(out_imm32), 64'd5);
`else
    check_eq("csrrwi_type", 64'(out_type32), 64'd0);
    check_eq("csrrwi_imm", 64'(out_imm32), 64'd0);
`endif
    step(0, 32'h0, 5'd0, 1, 0);

    // Backpressure: tag 3 held off until the consumer drains.
    step(1, 32'h00100093, 5'd1, 0, 0);
    step(1, 32'h00200093, 5'd2, 0, 0);
    check_eq("full_in_ready", 64'(in_ready32), 64'd0);
    step(1, 32'h00300093, 5'd3, 0, 0);
    check_eq("hold_tag", 64'(out_tag32), 64'd1);
    for (int k = 0; k < 4; k++) step(1, 32'h00300093, 5'd3, 1, 0);
    step(0, 32'h0, 5'd0, 1, 0);

    // Flush with a concurrent push: the push is lost.
    step(1, 32'h00100093, 5'd4, 0, 0);
    step(1, 32'h00200093, 5'd5, 0, 0);
    step(1, 32'h00300093, 5'd6, 1, 1);
    check_eq("flush_valid", 64'(out_valid32), 64'd0);
    step(1, 32'h00000013, 5'd1, 0, 0);
    check_eq("nop_ill", 64'(out_illegal32), 64'd0);
    step(0, 32'h0, 5'd0, 1, 0);
    step(1, 32'h00000000, 5'd2, 0, 0);
    check_eq("zero_ill", 64'(out_illegal32), 64'd1);
    step(1, 32'h00000013, 5'd3, 0, 0);

    // Asynchronous reset with a full queue.
    #2 rst = 1'b1;
    in_valid = 1'b0;
    mq_instr.delete(); mq_tag.delete();
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    @(negedge clk);
    check_outputs();

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, gen_instr(), TAG_W'($urandom()),
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
